// File: rtl/fphub_dec_if.sv
// Valid/ready word channel between the FPHUB decoder and its neighbours.
interface fphub_dec_if #(
  parameter int W = 32
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fphub_to_ieee_converter.sv
// FPHUB -> IEEE-754 decoder, 2-stage valid/ready pipeline, latency 2, 1 word/cycle, stalls hold both stages.
// Optional out_status_o {overflow, inexact, invalid} under `FPHUB_DEC_STATUS_EN.
module fphub_to_ieee_converter #(
  parameter int M = 23,
  parameter int E = 8
) (
  input  logic         clk,
  input  logic         rst,
  fphub_dec_if.slave   in_i,
  fphub_dec_if.master  out_o
`ifdef FPHUB_DEC_STATUS_EN
  ,
  output logic [2:0]   out_status_o
`endif
);

  localparam int W = E + M + 1;

  typedef enum logic [1:0] {CLS_ZERO, CLS_INF, CLS_NAN, CLS_NORM} cls_e;

  logic         v1_q, v1_d, v2_q, v2_d;
  logic         load1, load2;
  logic         s1_sign_q;
  logic [E-1:0] s1_exp_q;
  logic [M-1:0] s1_man_q;
  cls_e         s1_cls_q, cls_d;
  logic [W-1:0] res_q, res_d;
  logic [M:0]   man_sum;
  logic [E:0]   exp_inc;
  logic [E-1:0] in_exp;
  logic [M-1:0] in_man;

  assign load2      = !v2_q || out_o.ready;
  assign load1      = !v1_q || load2;
  assign in_i.ready = load1;
  assign out_o.valid = v2_q;
  assign out_o.data  = res_q;

  assign v1_d = load1 ? in_i.valid : v1_q;
  assign v2_d = load2 ? v1_q : v2_q;

  assign in_exp = in_i.data[W-2:M];
  assign in_man = in_i.data[M-1:0];

  always_comb begin
    cls_d = CLS_NORM;
    if (in_exp == '0)
      cls_d = CLS_ZERO;
    else if (&in_exp)
      cls_d = (|in_man) ? CLS_NAN : CLS_INF;
  end

  // HUB value sits exactly on the tie; m[0] decides the even neighbour.
  assign man_sum = {1'b0, s1_man_q} + {{M{1'b0}}, 1'b1};
  assign exp_inc = {1'b0, s1_exp_q} + {{E{1'b0}}, 1'b1};

  always_comb begin
    res_d = '0;
    case (s1_cls_q)
      CLS_ZERO: res_d = {s1_sign_q, {E{1'b0}}, {M{1'b0}}};
      CLS_INF:  res_d = {s1_sign_q, {E{1'b1}}, {M{1'b0}}};
      CLS_NAN:  res_d = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
      default: begin
        if (!s1_man_q[0])
          res_d = {s1_sign_q, s1_exp_q, s1_man_q};
        else if (!man_sum[M])
          res_d = {s1_sign_q, s1_exp_q, man_sum[M-1:0]};
        else if (exp_inc == {1'b0, {E{1'b1}}})
          res_d = {s1_sign_q, {E{1'b1}}, {M{1'b0}}};
        else
          res_d = {s1_sign_q, exp_inc[E-1:0], {M{1'b0}}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_man_q  <= '0;
      s1_cls_q  <= CLS_ZERO;
      res_q     <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (load1 && in_i.valid) begin
        s1_sign_q <= in_i.data[W-1];
        s1_exp_q  <= in_exp;
        s1_man_q  <= in_man;
        s1_cls_q  <= cls_d;
      end
      if (load2 && v1_q)
        res_q <= res_d;
    end
  end

`ifdef FPHUB_DEC_STATUS_EN
  logic [2:0] status_q, status_d;
  logic       ovf_d;

  assign ovf_d = (s1_cls_q == CLS_NORM) && s1_man_q[0] && man_sum[M] &&
                 (exp_inc == {1'b0, {E{1'b1}}});
  assign status_d = {ovf_d, (s1_cls_q == CLS_NORM), (s1_cls_q == CLS_NAN)};
  assign out_status_o = status_q;

  always_ff @(posedge clk) begin
    if (rst)
      status_q <= 3'b000;
    else if (load2 && v1_q)
      status_q <= status_d;
  end
`endif

endmodule

// File: tb/tb_fphub_to_ieee_converter.sv
// Bench for fphub_to_ieee_converter: directed plan scenarios plus randomized traffic against a word-level model.
module tb_fphub_to_ieee_converter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fphub_dec_if #(.W(32)) in_if ();
  fphub_dec_if #(.W(32)) out_if ();

`ifdef FPHUB_DEC_STATUS_EN
  logic [2:0] out_status;
`endif

  fphub_to_ieee_converter #(.M(23), .E(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .in_i  (in_if),
    .out_o (out_if)
`ifdef FPHUB_DEC_STATUS_EN
    ,
    .out_status_o (out_status)
`endif
  );

  // Exponent and fraction treated as one integer: rounding up the fraction carries into the exponent.
  function automatic logic [34:0] ref_conv(input logic [31:0] x);
    logic [7:0]  e;
    logic [22:0] m;
    logic [31:0] mag;
    e = x[30:23];
    m = x[22:0];
    if (e == 8'h00) return {3'b000, x[31], 31'd0};
    if (e == 8'hff) return (m == 23'd0) ? {3'b000, x[31], 8'hff, 23'd0} : {3'b001, 32'h7FC00000};
    if (!m[0]) return {3'b010, x};
    mag = {1'b0, x[30:0]} + 32'd1;
    return {(mag[30:23] == 8'hff), 2'b10, x[31], mag[30:0]};
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 5))
      0: x[30:23] = 8'h00;
      1: begin x[30:23] = 8'hff; x[22:0] = 23'd0; end
      2: x[30:23] = 8'hff;
      3: begin x[30:23] = 8'hfe; x[22:0] = '1; end
      default: ;
    endcase
    return x;
  endfunction

  // Drive one cycle's inputs at the falling edge and sample the settled outputs.
  task automatic tick(input logic iv, input logic [31:0] id, input logic ordy,
                      output logic acc, output logic ir, output logic ov,
                      output logic [31:0] od, output logic [2:0] ost);
    @(negedge clk);
    in_if.valid  = iv;
    in_if.data   = id;
    out_if.ready = ordy;
    #1;
    ir  = in_if.ready;
    acc = iv && in_if.ready;
    ov  = out_if.valid;
    od  = out_if.data;
`ifdef FPHUB_DEC_STATUS_EN
    ost = out_status;
`else
    ost = 3'b000;
`endif
  endtask

  task automatic test_reset();
    logic acc, ir, ov;
    logic [31:0] od;
    logic [2:0] ost;
    rst = 1'b1;
    in_if.valid = 1'b0;
    in_if.data = '0;
    out_if.ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick(1'b0, 32'd0, 1'b1, acc, ir, ov, od, ost);
    checks++;
    if (ov !== 1'b0 || od !== 32'd0 || ir !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h in_ready=%b, expected 0 00000000 1", ov, od, ir);
    end
    checks++;
    if (ost !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got %b expected 000", ost);
    end
    for (int t = 0; t < 3; t++) begin
      tick(1'b0, 32'd0, 1'b1, acc, ir, ov, od, ost);
      checks++;
      if (ov !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid: cycle %0d got %b expected 0", t, ov);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] din [3] = '{32'h3F800000, 32'h3F800001, 32'h3FFFFFFF};
    logic [31:0] dexp[3] = '{32'h3F800000, 32'h3F800002, 32'h40000000};
    logic acc, ir, ov;
    logic [31:0] od;
    logic [2:0] ost;
    for (int t = 0; t < 5; t++) begin
      tick(t < 3, (t < 3) ? din[t] : 32'd0, 1'b1, acc, ir, ov, od, ost);
      if (t < 3) begin
        checks++;
        if (acc !== 1'b1) begin
          errors++;
          $display("FAIL b2b_accept: cycle %0d in_ready=%b expected 1", t, ir);
        end
      end
      checks++;
      if (t < 2 && ov !== 1'b0) begin
        errors++;
        $display("FAIL b2b_latency: cycle %0d out_valid=%b expected 0", t, ov);
      end else if (t >= 2 && (ov !== 1'b1 || od !== dexp[t-2])) begin
        errors++;
        $display("FAIL b2b_data: cycle %0d valid=%b data=%h expected 1 %h", t, ov, od, dexp[t-2]);
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] din [4] = '{32'h7F7FFFFF, 32'h00000005, 32'hFF800000, 32'hFF800001};
    logic [31:0] dexp[4] = '{32'h7F800000, 32'h00000000, 32'hFF800000, 32'h7FC00000};
    logic [2:0]  sexp[4] = '{3'b110, 3'b000, 3'b000, 3'b001};
    logic acc, ir, ov;
    logic [31:0] od;
    logic [2:0] ost;
    for (int t = 0; t < 6; t++) begin
      tick(t < 4, (t < 4) ? din[t] : 32'd0, 1'b1, acc, ir, ov, od, ost);
      if (t >= 2) begin
        checks++;
        if (ov !== 1'b1 || od !== dexp[t-2]) begin
          errors++;
          $display("FAIL special_data: input %h got valid=%b data=%h expected %h", din[t-2], ov, od, dexp[t-2]);
        end
`ifdef FPHUB_DEC_STATUS_EN
        checks++;
        if (ost !== sexp[t-2]) begin
          errors++;
          $display("FAIL special_status: input %h got %b expected %b", din[t-2], ost, sexp[t-2]);
        end
`endif
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] din [3] = '{32'h3F800001, 32'h40490FDB, 32'hBF800000};
    logic [31:0] dexp[3] = '{32'h3F800002, 32'h40490FDC, 32'hBF800000};
    logic acc, ir, ov, pending;
    logic [31:0] od;
    logic [2:0] ost;
    int k;
    for (int t = 0; t < 2; t++) begin
      tick(1'b1, din[t], 1'b0, acc, ir, ov, od, ost);
      checks++;
      if (acc !== 1'b1) begin
        errors++;
        $display("FAIL stall_accept: input %0d in_ready=%b expected 1", t, ir);
      end
    end
    for (int t = 0; t < 4; t++) begin
      tick(1'b1, din[2], 1'b0, acc, ir, ov, od, ost);
      checks++;
      if (ir !== 1'b0 || ov !== 1'b1 || od !== dexp[0]) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d in_ready=%b valid=%b data=%h expected 0 1 %h", t, ir, ov, od, dexp[0]);
      end
    end
    k = 0;
    pending = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick(pending, din[2], 1'b1, acc, ir, ov, od, ost);
      if (acc) pending = 1'b0;
      if (ov) begin
        checks++;
        if (k >= 3 || od !== dexp[k]) begin
          errors++;
          $display("FAIL stall_release: output %0d got %h expected %h", k, od, (k < 3) ? dexp[k] : 32'hxxxxxxxx);
        end
        k++;
      end
    end
    checks++;
    if (k != 3) begin
      errors++;
      $display("FAIL stall_count: got %0d outputs expected 3", k);
    end
  endtask

  task automatic test_reset_mid();
    logic acc, ir, ov;
    logic [31:0] od;
    logic [2:0] ost;
    int seen;
    tick(1'b1, 32'h3F800000, 1'b0, acc, ir, ov, od, ost);
    tick(1'b1, 32'h40000001, 1'b0, acc, ir, ov, od, ost);
    @(negedge clk);
    rst = 1'b1;
    in_if.valid = 1'b0;
    out_if.ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset: valid=%b in_ready=%b expected 0 1", out_if.valid, in_if.ready);
    end
    seen = 0;
    for (int t = 0; t < 5; t++) begin
      tick(1'b0, 32'd0, 1'b1, acc, ir, ov, od, ost);
      if (ov) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midreset_stale: got %0d outputs expected 0", seen);
    end
  endtask

  task automatic test_random();
    logic [34:0] q[$];
    logic [34:0] e;
    logic acc, ir, ov, iv, ordy;
    logic prev_hold;
    logic [31:0] od, x, prev_od;
    logic [2:0] ost;
    prev_hold = 1'b0;
    prev_od = '0;
    for (int t = 0; t < 420; t++) begin
      iv   = (t < 400) ? ($urandom_range(0, 3) != 0) : 1'b0;
      ordy = (t < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
      x    = gen_word();
      tick(iv, x, ordy, acc, ir, ov, od, ost);
      if (prev_hold) begin
        checks++;
        if (ov !== 1'b1 || od !== prev_od) begin
          errors++;
          $display("FAIL rand_stable: cycle %0d valid=%b data=%h expected 1 %h", t, ov, od, prev_od);
        end
      end
      if (ov && ordy) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: cycle %0d got %h expected none", t, od);
        end else begin
          e = q.pop_front();
          if (od !== e[31:0]) begin
            errors++;
            $display("FAIL rand_data: cycle %0d got %h expected %h", t, od, e[31:0]);
          end
`ifdef FPHUB_DEC_STATUS_EN
          checks++;
          if (ost !== e[34:32]) begin
            errors++;
            $display("FAIL rand_status: cycle %0d got %b expected %b", t, ost, e[34:32]);
          end
`endif
        end
      end
      if (acc) q.push_back(ref_conv(x));
      prev_hold = ov && !ordy;
      prev_od = od;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got %0d results missing expected 0", q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    in_if.valid = 1'b0;
    in_if.data = '0;
    out_if.ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_specials();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
